// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// Operands arrive over a valid/ready handshake. One full_adder cell adds them
// one bit per clock, LSB first. Sum, carry-out and signed overflow are
// returned over a second valid/ready handshake.
// Optional feature: define SERIAL_ADD_SUB_EN to honour the sub request (a-b).

// Single-bit full adder cell shared across all bit positions.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_init;
  logic             carry_init;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction as a + ~b + 1: invert b at capture and force the initial carry.
  always_comb begin
    b_init     = b;
    carry_init = cin;
    if (sub) begin
      b_init     = ~b;
      carry_init = 1'b1;
    end
  end
`else
  logic unused_sub;
  assign unused_sub = sub;

  // Add-only build: operands and carry-in pass straight through.
  always_comb begin
    b_init     = b;
    carry_init = cin;
  end
`endif

  // Sequencer: accept operands, shift one bit per clock, hold result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b_init;
            carry    <= carry_init;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
          carry  <= fa_co;
          if (cnt == LAST) begin
            // The visible sum is only updated here, so the previous result
            // stays stable while the shift register fills.
            sum       <= {fa_s, sum_sr[WIDTH-1:1]};
            cout      <= fa_co;
            ovf       <= carry ^ fa_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Honours SERIAL_ADD_SUB_EN to select the subtract or add-only expectations.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] prev_sum;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands at a negedge, accept on the next posedge, then scramble
  // the inputs so any sampling during RUN would corrupt the result.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tc, input logic ts);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'hC3; b = 8'h3C; cin = 1'b1; sub = ~ts;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  // Called 1ns after the accept edge; expects out_valid exactly 8 edges later.
  task automatic finish_op(input string tag, input logic [7:0] es,
                           input logic ec, input logic eo);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 4) check({tag, "_sum_held_in_run"}, {24'd0, sum}, {24'd0, prev_sum});
    end
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    prev_sum = es;
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_in_ready_after_hs"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_out_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_busy_after_hs"}, {31'd0, busy}, 32'd0);
      check({tag, "_sum_retained"}, {24'd0, sum}, {24'd0, es});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1; prev_sum = '0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 0x5A + 0x33 = 0x8D: no unsigned carry, positive+positive -> negative
    start_op(8'h5A, 8'h33, 1'b0, 1'b0);
    finish_op("add_5a_33", 8'h8D, 1'b0, 1'b1);

    // -1 + 1 = 0 with carry out, no signed overflow
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    finish_op("add_ff_01", 8'h00, 1'b1, 1'b0);

    // carry-in alone propagates through all ones
    start_op(8'hFF, 8'h00, 1'b1, 1'b0);
    finish_op("add_ff_00_c1", 8'h00, 1'b1, 1'b0);

    // Backpressure: hold the result for 5 cycles while junk in_valid pulses arrive
    out_ready = 1'b0;
    start_op(8'h01, 8'h02, 1'b0, 1'b0);
    finish_op("bp_01_02", 8'h03, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
      @(posedge clk);
      #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_sum", {24'd0, sum}, 32'h03);
    end

    // Output handshake with in_valid high: the new op must wait one cycle
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b1;
    @(posedge clk);
    #1;
    check("hs_no_accept_busy", {31'd0, busy}, 32'd0);
    check("hs_no_accept_in_ready", {31'd0, in_ready}, 32'd1);
    check("hs_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("late_accept_busy", {31'd0, busy}, 32'd1);
    finish_op("add_0f_01_c1", 8'h11, 1'b0, 1'b0);

    // Asynchronous reset while bit 3 is being processed
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrun_rst_busy", {31'd0, busy}, 32'd0);
    check("midrun_rst_sum", {24'd0, sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_sum = '0;

    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    finish_op("add_7f_01", 8'h80, 1'b0, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
    start_op(8'h10, 8'h20, 1'b0, 1'b1);
    finish_op("sub_10_20", 8'hF0, 1'b0, 1'b0);
    start_op(8'h80, 8'h01, 1'b0, 1'b1);
    finish_op("sub_80_01", 8'h7F, 1'b1, 1'b1);
`else
    start_op(8'h10, 8'h20, 1'b0, 1'b1);
    finish_op("nosub_10_20", 8'h30, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
